// File: rtl/time_set_sequencer.sv
// Panel-control sequencer for the clock counters: synchronised, debounced set-mode FSM with auto-repeat and blink.
// Latency: CP3 rise -> sec_tick 3 cycles, QD rise -> inc DB_CYCLES+3 cycles; no backpressure, strobes are fire-and-forget.
module time_set_sequencer #(
    parameter int DB_CYCLES     = 20,
    parameter int REPEAT_DELAY  = 500,
    parameter int REPEAT_PERIOD = 100,
    parameter int BLINK_HALF    = 250
) (
    input  logic       CP2,
    input  logic       CLR_n,
    input  logic       CP3,
    input  logic       K0,
    input  logic       K1,
    input  logic       K2,
    input  logic       QD,
    output logic       sec_tick,
    output logic       sec_clr,
    output logic       hour_inc,
    output logic       min_inc,
    output logic       blink_hour,
    output logic       blink_min,
    output logic [1:0] mode
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_HOLD     = 2'd1,
        ST_SET_HOUR = 2'd2,
        ST_SET_MIN  = 2'd3
    } state_t;

    localparam int DB_W = $clog2(DB_CYCLES + 1);
    localparam int RP_W = $clog2(REPEAT_DELAY + 1);
    localparam int BL_W = $clog2(BLINK_HALF + 1);

    localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DB_CYCLES - 1);
    localparam logic [RP_W-1:0] RPT_FIRE   = RP_W'(REPEAT_DELAY);
    // After a repeat pulse the counter restarts so the next hit is REPEAT_PERIOD cycles away.
    localparam logic [RP_W-1:0] RPT_RELOAD = RP_W'(REPEAT_DELAY - REPEAT_PERIOD + 1);
    localparam logic [BL_W-1:0] BL_LAST    = BL_W'(BLINK_HALF - 1);

    logic [4:0]      sync1_q;
    logic [4:0]      sync2_q;
    logic            k0_s;
    logic            k1_s;
    logic            k2_s;
    logic            qd_s;
    logic            cp3_s;

    state_t          state_q;
    state_t          state_d;
    logic            state_chg;
    logic            in_set_q;
    logic            in_set_d;

    logic            cp3_prev_q;
    logic            cp3_rise;

    logic            qd_db_q;
    logic            qd_db_d;
    logic            qd_db_prev_q;
    logic [DB_W-1:0] db_cnt_q;
    logic [DB_W-1:0] db_cnt_d;
    logic            press;

    logic            rep_act_q;
    logic            rep_act_d;
    logic [RP_W-1:0] rep_cnt_q;
    logic [RP_W-1:0] rep_cnt_d;
    logic            rep_hit;
    logic            fire;

    logic            phase_q;
    logic            phase_d;
    logic [BL_W-1:0] bl_cnt_q;
    logic [BL_W-1:0] bl_cnt_d;

    logic            sec_tick_q;
    logic            sec_clr_q;
    logic            hour_inc_q;
    logic            min_inc_q;
    logic            blink_hour_q;
    logic            blink_min_q;

    assign k0_s  = sync2_q[0];
    assign k1_s  = sync2_q[1];
    assign k2_s  = sync2_q[2];
    assign qd_s  = sync2_q[3];
    assign cp3_s = sync2_q[4];

    // Same selection rule from every state: K0 low wins, then K1 over K2.
    always_comb begin
        state_d = state_q;
        if (!k0_s) begin
            state_d = ST_RUN;
        end else if (k1_s) begin
            state_d = ST_SET_HOUR;
        end else if (k2_s) begin
            state_d = ST_SET_MIN;
        end else begin
            state_d = ST_HOLD;
        end
    end

    assign state_chg = (state_d != state_q);
    assign in_set_q  = (state_q == ST_SET_HOUR) || (state_q == ST_SET_MIN);
    assign in_set_d  = (state_d == ST_SET_HOUR) || (state_d == ST_SET_MIN);
    assign cp3_rise  = cp3_s && !cp3_prev_q;

    always_comb begin
        qd_db_d  = qd_db_q;
        db_cnt_d = '0;
        if (qd_s != qd_db_q) begin
            if (db_cnt_q == DB_LAST) begin
                qd_db_d = qd_s;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    assign press   = qd_db_q && !qd_db_prev_q;
    assign rep_hit = rep_act_q && (rep_cnt_q == RPT_FIRE);
    assign fire    = in_set_q && !state_chg && qd_db_q && (press || rep_hit);

    // Repeat only survives while the debounced button stays down in an unchanged set state.
    always_comb begin
        rep_act_d = rep_act_q;
        rep_cnt_d = rep_cnt_q;
        if (!qd_db_q || !in_set_q || state_chg) begin
            rep_act_d = 1'b0;
            rep_cnt_d = '0;
        end else if (press) begin
            rep_act_d = 1'b1;
            rep_cnt_d = RP_W'(1);
        end else if (rep_hit) begin
            rep_cnt_d = RPT_RELOAD;
        end else if (rep_act_q) begin
            rep_cnt_d = rep_cnt_q + 1'b1;
        end
    end

    always_comb begin
        phase_d  = phase_q;
        bl_cnt_d = bl_cnt_q;
        if (in_set_d && state_chg) begin
            phase_d  = 1'b1;
            bl_cnt_d = '0;
        end else if (in_set_q) begin
            if (bl_cnt_q == BL_LAST) begin
                bl_cnt_d = '0;
                phase_d  = !phase_q;
            end else begin
                bl_cnt_d = bl_cnt_q + 1'b1;
            end
        end else begin
            phase_d  = 1'b0;
            bl_cnt_d = '0;
        end
    end

    always_ff @(posedge CP2 or negedge CLR_n) begin
        if (!CLR_n) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            state_q      <= ST_RUN;
            cp3_prev_q   <= 1'b0;
            qd_db_q      <= 1'b0;
            qd_db_prev_q <= 1'b0;
            db_cnt_q     <= '0;
            rep_act_q    <= 1'b0;
            rep_cnt_q    <= '0;
            phase_q      <= 1'b0;
            bl_cnt_q     <= '0;
            sec_tick_q   <= 1'b0;
            sec_clr_q    <= 1'b0;
            hour_inc_q   <= 1'b0;
            min_inc_q    <= 1'b0;
            blink_hour_q <= 1'b0;
            blink_min_q  <= 1'b0;
        end else begin
            sync1_q      <= {CP3, QD, K2, K1, K0};
            sync2_q      <= sync1_q;
            state_q      <= state_d;
            cp3_prev_q   <= cp3_s;
            qd_db_q      <= qd_db_d;
            qd_db_prev_q <= qd_db_q;
            db_cnt_q     <= db_cnt_d;
            rep_act_q    <= rep_act_d;
            rep_cnt_q    <= rep_cnt_d;
            phase_q      <= phase_d;
            bl_cnt_q     <= bl_cnt_d;
            sec_tick_q   <= cp3_rise && (state_q == ST_RUN);
            sec_clr_q    <= (state_q != ST_RUN) && (state_d == ST_RUN);
            hour_inc_q   <= fire && (state_q == ST_SET_HOUR);
            min_inc_q    <= fire && (state_q == ST_SET_MIN);
            blink_hour_q <= (state_d == ST_SET_HOUR) && phase_d;
            blink_min_q  <= (state_d == ST_SET_MIN) && phase_d;
        end
    end

    assign sec_tick   = sec_tick_q;
    assign sec_clr    = sec_clr_q;
    assign hour_inc   = hour_inc_q;
    assign min_inc    = min_inc_q;
    assign blink_hour = blink_hour_q;
    assign blink_min  = blink_min_q;
    assign mode       = state_q;

endmodule

// File: tb/tb_time_set_sequencer.sv
// Directed scenarios with randomised timing; strobe cycles are logged and compared against times computed from the
// panel-timing rules (sync + debounce + repeat arithmetic).
module tb_time_set_sequencer;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 5;
    localparam int BH = 8;

    logic       CP2   = 1'b0;
    logic       CLR_n = 1'b0;
    logic       CP3   = 1'b0;
    logic       K0    = 1'b0;
    logic       K1    = 1'b0;
    logic       K2    = 1'b0;
    logic       QD    = 1'b0;
    logic       sec_tick;
    logic       sec_clr;
    logic       hour_inc;
    logic       min_inc;
    logic       blink_hour;
    logic       blink_min;
    logic [1:0] mode;

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;
    int both_cnt = 0;
    int hour_log[$];
    int min_log[$];
    int tick_log[$];
    int clr_log[$];

    time_set_sequencer #(
        .DB_CYCLES    (DB),
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP),
        .BLINK_HALF   (BH)
    ) dut (
        .CP2       (CP2),
        .CLR_n     (CLR_n),
        .CP3       (CP3),
        .K0        (K0),
        .K1        (K1),
        .K2        (K2),
        .QD        (QD),
        .sec_tick  (sec_tick),
        .sec_clr   (sec_clr),
        .hour_inc  (hour_inc),
        .min_inc   (min_inc),
        .blink_hour(blink_hour),
        .blink_min (blink_min),
        .mode      (mode)
    );

    always #5 CP2 = ~CP2;

    always @(posedge CP2) cyc <= cyc + 1;

    always @(negedge CP2) begin
        if (hour_inc) hour_log.push_back(cyc);
        if (min_inc)  min_log.push_back(cyc);
        if (sec_tick) tick_log.push_back(cyc);
        if (sec_clr)  clr_log.push_back(cyc);
        if (hour_inc && min_inc) both_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(negedge CP2);
    endtask

    task automatic clear_logs();
        hour_log.delete();
        min_log.delete();
        tick_log.delete();
        clr_log.delete();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_log(input string tag, input int got[$], input int exp[$]);
        chk({tag, "_count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            chk($sformatf("%s_%0d", tag, i), got[i], exp[i]);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_sec_tick"},   32'(sec_tick),   32'd0);
        chk({tag, "_sec_clr"},    32'(sec_clr),    32'd0);
        chk({tag, "_hour_inc"},   32'(hour_inc),   32'd0);
        chk({tag, "_min_inc"},    32'(min_inc),    32'd0);
        chk({tag, "_blink_hour"}, 32'(blink_hour), 32'd0);
        chk({tag, "_blink_min"},  32'(blink_min),  32'd0);
        chk({tag, "_mode"},       32'(mode),       32'd0);
    endtask

    initial begin
        int t;
        int k;
        int r;
        int d;
        int n;
        int exp_q[$];

        // Reset state
        step(3);
        chk_all_zero("reset");
        CLR_n = 1'b1;
        step(2);
        clear_logs();

        // RUN: one tick per CP3 rise, 3 cycles later
        step($urandom_range(0, 20));
        exp_q = {};
        for (int p = 0; p < 4; p++) begin
            CP3 = 1'b1;
            exp_q.push_back(cyc + 3);
            step(32);
            CP3 = 1'b0;
            step(32);
        end
        step(5);
        chk_log("run_tick", tick_log, exp_q);
        chk("run_no_hour", hour_log.size(), 0);
        chk("run_no_min", min_log.size(), 0);
        chk("run_no_clr", clr_log.size(), 0);
        chk("run_mode", 32'(mode), 32'd0);

        // SET_HOUR: clean 10-cycle press, CP3 rise dropped, exit gives sec_clr
        K0 = 1'b1;
        K1 = 1'b1;
        step(5);
        chk("set_hour_mode", 32'(mode), 32'd2);
        clear_logs();
        QD = 1'b1;
        t = cyc + DB + 3;
        step(10);
        QD = 1'b0;
        step($urandom_range(2, 6));
        CP3 = 1'b1;
        step(20);
        CP3 = 1'b0;
        step(20);
        exp_q = {t};
        chk_log("hour_single", hour_log, exp_q);
        chk("hour_single_no_min", min_log.size(), 0);
        chk("set_no_tick", tick_log.size(), 0);
        K0 = 1'b0;
        d = cyc;
        step(10);
        exp_q = {d + 3};
        chk_log("sec_clr_once", clr_log, exp_q);
        chk("after_exit_mode", 32'(mode), 32'd0);

        // SET_MIN: bounce then hold; press, first repeat after RD, then every RP until release
        K0 = 1'b1;
        K1 = 1'b0;
        K2 = 1'b1;
        step(5);
        chk("set_min_mode", 32'(mode), 32'd3);
        clear_logs();
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) begin
            QD = 1'b1;
            step(1);
            QD = 1'b0;
            step(1);
        end
        QD = 1'b1;
        t = cyc + DB + 3;
        k = $urandom_range(2, 4);
        // Release so the debounced fall lands midway between two repeat slots.
        r = t + RD + RP * k - DB;
        step(r - cyc);
        QD = 1'b0;
        step(40);
        exp_q = {t};
        for (int j = 0; j <= k; j++) exp_q.push_back(t + RD + RP * j);
        chk_log("min_repeat", min_log, exp_q);
        chk("min_repeat_no_hour", hour_log.size(), 0);

        // SET_HOUR held, switch to SET_MIN mid-repeat: held QD must not carry over
        K1 = 1'b1;
        step(5);
        chk("switch_start_mode", 32'(mode), 32'd2);
        clear_logs();
        QD = 1'b1;
        t = cyc + DB + 3;
        step(t + RD - cyc);
        K1 = 1'b0;
        step(30);
        chk("switch_mode", 32'(mode), 32'd3);
        exp_q = {t, t + RD};
        chk_log("hour_before_switch", hour_log, exp_q);
        chk("min_held_across", min_log.size(), 0);
        QD = 1'b0;
        step(15);
        clear_logs();
        QD = 1'b1;
        t = cyc + DB + 3;
        step(10);
        QD = 1'b0;
        step(20);
        exp_q = {t};
        chk_log("min_after_repress", min_log, exp_q);
        chk("repress_no_hour", hour_log.size(), 0);

        // HOLD: presses ignored, no blink
        K2 = 1'b0;
        step(5);
        chk("hold_mode", 32'(mode), 32'd1);
        clear_logs();
        QD = 1'b1;
        step(10);
        QD = 1'b0;
        step(30);
        chk("hold_no_hour", hour_log.size(), 0);
        chk("hold_no_min", min_log.size(), 0);
        chk("hold_blink_hour", 32'(blink_hour), 32'd0);
        chk("hold_blink_min", 32'(blink_min), 32'd0);

        // Enter SET_HOUR: blink_hour 1 for BH cycles, 0 for BH, ...
        K1 = 1'b1;
        step(3);
        for (int i = 0; i < 4 * BH; i++) begin
            chk($sformatf("blink_hour_%0d", i), 32'(blink_hour),
                ((i / BH) % 2 == 0) ? 32'd1 : 32'd0);
            if (i % BH == 0) chk($sformatf("blink_min_%0d", i), 32'(blink_min), 32'd0);
            step(1);
        end

        // Reset mid-repeat: immediate clear, fresh press needed afterwards
        clear_logs();
        QD = 1'b1;
        t = cyc + DB + 3;
        step(t + RD + 2 - cyc);
        chk("pre_reset_repeat_seen", hour_log.size(), 2);
        #2;
        CLR_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        QD = 1'b0;
        step(4);
        chk_all_zero("in_reset");
        CLR_n = 1'b1;
        clear_logs();
        step(1);
        chk("post_reset_mode", 32'(mode), 32'd0);
        step(20);
        chk("post_reset_no_hour", hour_log.size(), 0);
        chk("post_reset_no_min", min_log.size(), 0);
        chk("post_reset_set_mode", 32'(mode), 32'd2);
        QD = 1'b1;
        t = cyc + DB + 3;
        step(10);
        QD = 1'b0;
        step(20);
        exp_q = {t};
        chk_log("hour_after_reset", hour_log, exp_q);

        chk("never_both_inc", both_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
